// File: rtl/alu_seq_core.sv
// Sequential ALU with iterative shift-add multiply and a scanned hex display of the result.
// Optional macro ALU_SEQ_SEVSEG_EN compiles in the seven-segment scan logic.
module alu_seq_core #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 c_out,
  output logic                 zero,
  output logic [6:0]           CA,
  output logic [DIGITS-1:0]    AN
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_l_q, a_l_d, b_l_q, b_l_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 c_out_q, c_out_d;
  logic                 zero_q, zero_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_c_s;
  logic [WIDTH:0]       wide_s;

  // Single-cycle ALU datapath on the live operands
  always_comb begin
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    wide_s    = '0;
    case (op)
      3'b000: begin
        wide_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        alu_res_s = wide_s[WIDTH-1:0];
        alu_c_s   = wide_s[WIDTH];
      end
      3'b001: begin
        // borrow shows up in the extra top bit; carry-out is its inverse
        wide_s    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
        alu_res_s = wide_s[WIDTH-1:0];
        alu_c_s   = ~wide_s[WIDTH];
      end
      3'b010:  alu_res_s = a & b;
      3'b011:  alu_res_s = a | b;
      3'b100:  alu_res_s = a ^ b;
      3'b101:  alu_res_s = (b >= WIDTH_V) ? {WIDTH{1'b0}} : (a << b);
      3'b110:  alu_res_s = (b >= WIDTH_V) ? {WIDTH{1'b0}} : (a >> b);
      default: alu_res_s = '0;
    endcase
  end

  // FSM next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    a_l_d    = a_l_q;
    b_l_d    = b_l_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start && (op == 3'b111)) begin
          a_l_d   = a;
          b_l_d   = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end else if (start) begin
          result_d = {{WIDTH{1'b0}}, alu_res_s};
          c_out_d  = alu_c_s;
          zero_d   = (alu_res_s == {WIDTH{1'b0}});
          state_d  = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = acc_q + (a_l_q[cnt_q] ? ({{WIDTH{1'b0}}, b_l_q} << cnt_q) : {2*WIDTH{1'b0}});
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          result_d = acc_d;
          c_out_d  = 1'b0;
          zero_d   = (acc_d == {2*WIDTH{1'b0}});
          state_d  = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_l_q    <= '0;
      b_l_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_l_q    <= a_l_d;
      b_l_q    <= b_l_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;

`ifdef ALU_SEQ_SEVSEG_EN
  localparam int NIBS = (2 * WIDTH) / 4;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  logic [SCAN_DIV-1:0] scan_q, scan_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          ca_q, ca_d;
  int                  dig_s;

  // Decode from next-cycle counter/result so the registered drive lines up with the counter
  always_comb begin
    scan_d = scan_q + {{(SCAN_DIV-1){1'b0}}, 1'b1};
    dig_s  = int'(scan_d[SCAN_DIV-1 -: 3]) % DIGITS;
    an_d   = '1;
    ca_d   = 7'h7F;
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (i != dig_s);
    end
    for (int i = 0; i < NIBS; i++) begin
      ca_d = (i == dig_s) ? hex7(result_d[4*i +: 4]) : ca_d;
    end
  end

  // Scan counter and display drive registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      an_q   <= ~{{(DIGITS-1){1'b0}}, 1'b1};
      ca_q   <= 7'b1000000;
    end else begin
      scan_q <= scan_d;
      an_q   <= an_d;
      ca_q   <= ca_d;
    end
  end

  assign CA = ca_q;
  assign AN = an_q;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (SCAN_DIV > 0) ? 1'b0 : 1'b0;
  assign CA = 7'h7F;
  assign AN = '1;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: vector table plus scoreboard, with
// hand-written multiply, abort-by-reset and display-scan sequences.
module tb_alu_seq_core;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [W-1:0] a, b;
  logic        c_in;
  logic        busy, done, c_out, zero;
  logic [2*W-1:0] result;
  logic [6:0]  CA;
  logic [7:0]  AN;

  alu_seq_core #(.WIDTH(W), .DIGITS(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .zero(zero),
    .CA(CA), .AN(AN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic [15:0] r;
    logic        c;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int accepted = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  // Scoreboard monitor: every done pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (busy === 1'b1 && done === 1'b1) chk("busy_done_overlap", 32'd1, 32'd0);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {16'd0, result}, {16'd0, e.r});
          chk("c_out", {31'd0, c_out}, {31'd0, e.c});
          chk("zero", {31'd0, zero}, {31'd0, e.z});
        end
      end
    end
  end

`ifdef ALU_SEQ_SEVSEG_EN
  logic [3:0] tb_scan;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_scan <= 4'd0;
    else        tb_scan <= tb_scan + 4'd1;
  end

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  endfunction
`endif

  task automatic do_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ci, input logic [15:0] er, input logic ec, input logic ez,
                       input bit glitch);
    int cyc;
    int bcyc;
    exp_t e;
    @(negedge clk);
    op = o; a = aa; b = bb; c_in = ci; start = 1'b1;
    e.r = er; e.c = ec; e.z = ez;
    exp_q.push_back(e);
    accepted++;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    bcyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcyc++;
      if (glitch && cyc == 3) begin
        start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, (o == 3'b111) ? W + 1 : 1);
    chk("busy_cycles", bcyc, (o == 3'b111) ? W : 0);
    @(posedge clk); #1;
    chk("done_single_cycle", {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    int saw_done;
    vecs[0]  = '{3'b000, 8'hF0, 8'h20, 1'b1, 16'h0011, 1'b1, 1'b0};
    vecs[1]  = '{3'b001, 8'h10, 8'h20, 1'b0, 16'h00F0, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 8'h20, 8'h20, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3]  = '{3'b101, 8'h81, 8'h01, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[4]  = '{3'b101, 8'h81, 8'h09, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{3'b110, 8'h80, 8'h07, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 8'hF0, 8'h3C, 1'b1, 16'h0030, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 8'hF0, 8'h0F, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 8'hAA, 8'hFF, 1'b0, 16'h0055, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0};
    vecs[10] = '{3'b111, 8'h00, 8'h05, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{3'b000, 8'hFF, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[12] = '{3'b001, 8'h05, 8'h02, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[13] = '{3'b110, 8'hFF, 8'h08, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[14] = '{3'b111, 8'h0C, 8'h0D, 1'b0, 16'h009C, 1'b0, 1'b0};
    vecs[15] = '{3'b101, 8'h01, 8'h07, 1'b0, 16'h0080, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
`ifdef ALU_SEQ_SEVSEG_EN
    chk("rst_an", {24'd0, AN}, 32'h0000_00FE);
    chk("rst_ca", {25'd0, CA}, 32'h0000_0040);
`else
    chk("rst_an", {24'd0, AN}, 32'h0000_00FF);
    chk("rst_ca", {25'd0, CA}, 32'h0000_007F);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].r, vecs[i].c, vecs[i].z, 1'b0);
    end

    // start pulsed and operands changed mid-multiply must be ignored
    do_op(3'b111, 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0, 1'b0, 1'b1);

    // leave a non-zero result and carry so the abort visibly clears them
    do_op(3'b000, 8'hF0, 8'h20, 1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    op = 3'b111; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_c_out", {31'd0, c_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    do_op(3'b000, 8'h03, 8'h04, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

    do_op(3'b111, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_SEVSEG_EN
    begin
      logic [15:0] shown;
      logic [15:0] nib_src;
      int d;
      shown = 16'hFE01;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        d = int'(tb_scan[3:1]);
        nib_src = shown >> (4 * (d % 4));
        chk("scan_an", {24'd0, AN}, {24'd0, ~(8'h01 << d)});
        chk("scan_ca", {25'd0, CA}, {25'd0, (d < 4) ? seg(nib_src[3:0]) : 7'h7F});
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("off_an", {24'd0, AN}, 32'h0000_00FF);
      chk("off_ca", {25'd0, CA}, 32'h0000_007F);
    end
`endif

    repeat (2) @(posedge clk);
    chk("done_count", done_cnt, accepted);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d expected 0", 1);
    $fatal(1, "timeout");
  end
endmodule
